memory_sequencer: RTL

- Sequences external memory accesses requested by the control unit over a 4-bit nibble-serial memory interface, which keeps the pin count low.
- Accepts one read or write request at a time, serialises command/address/data nibbles, and returns read data.
- Holds `busy` high so the control unit stalls its microcode state while an access is in flight.
- Sits between control_unit's memory_op decode and the chip pins.

---
 rtl/memory_sequencer_pkg.sv | 31 +++
 rtl/memory_sequencer_nibble_shifter.sv | 54 +++++
 rtl/memory_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/memory_sequencer_pkg.sv
// Shared types and constants for the nibble-serial memory sequencer.
// Optional read timeout is enabled by defining MEM_SEQ_TIMEOUT_EN.
package memory_sequencer_pkg;

    // Request opcode presented by the control unit
    typedef enum logic [1:0] {
        REQ_NOP   = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2,
        REQ_RSVD  = 2'd3
    } mem_req_e;

    // Access phases on the nibble bus
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_WAIT = 3'd3,
        ST_DATA = 3'd4,
        ST_DONE = 3'd5
    } mem_seq_state_e;

    localparam logic [3:0] CMD_READ_DEFAULT  = 4'h3;
    localparam logic [3:0] CMD_WRITE_DEFAULT = 4'h2;

    // Only reads and writes start a bus access; NOP and reserved are dropped
    function automatic logic is_access_op(input logic [1:0] op);
        return (op == REQ_READ) || (op == REQ_WRITE);
    endfunction

endpackage

// File: rtl/memory_sequencer_nibble_shifter.sv
// Nibble shift register: parallel load, shifts one nibble per cycle toward
// the MSB end. The top nibble feeds the memory bus, the bottom nibble
// collects nibbles returned by the memory.
module memory_sequencer_nibble_shifter #(
    parameter int WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_word_i,
    input  logic             shift_i,
    input  logic [3:0]       nib_i,
    output logic [3:0]       msb_nib_o,
    output logic [3:0]       lsb_nib_o
);

    localparam int NIBS = WIDTH / 4;

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] shifted;

    // Each nibble lane takes its lower neighbour; lane 0 takes the input nibble
    for (genvar gi = 0; gi < NIBS; gi++) begin : g_lane
        if (gi == 0) begin : g_in
            assign shifted[3:0] = nib_i;
        end else begin : g_mid
            assign shifted[gi*4 +: 4] = word_q[(gi-1)*4 +: 4];
        end
    end

    // Load has priority over shift
    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d = load_word_i;
        end else if (shift_i) begin
            word_d = shifted;
        end
    end

    // Shift register state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign msb_nib_o = word_q[WIDTH-1 -: 4];
    assign lsb_nib_o = word_q[3:0];

endmodule

// File: rtl/memory_sequencer.sv
// Sequences one read or write at a time over a 4-bit nibble-serial memory
// bus: command nibble, address nibbles MSB first, optional wait for read
// data, then two data nibbles. Holds busy while the access is in flight.
// Define MEM_SEQ_TIMEOUT_EN to abort reads that wait too long (error=1,
// rdata=8'hFF); without it a read waits for mem_ready indefinitely.
module memory_sequencer
    import memory_sequencer_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 16,
    parameter int         TIMEOUT_CYCLES = 15,
    parameter logic [3:0] CMD_READ       = CMD_READ_DEFAULT,
    parameter logic [3:0] CMD_WRITE      = CMD_WRITE_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            rdata,
    output logic                  error,
    output logic                  mem_cs_n,
    output logic [3:0]            mem_dout,
    output logic                  mem_oe,
    input  logic [3:0]            mem_din,
    input  logic                  mem_ready
);

    localparam int ADDR_NIBBLES = ADDR_WIDTH / 4;
    localparam int CNT_W        = (ADDR_NIBBLES > 2) ? $clog2(ADDR_NIBBLES) : 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_NIBBLES - 1);
    // Address and write data travel through one shifter back to back
    localparam int SHIFT_W = ADDR_WIDTH + 8;

    mem_seq_state_e   state_q;
    mem_req_e         op_q;
    logic [CNT_W-1:0] nib_cnt_q;
    logic             cs_n_q;
    logic             oe_q;
    logic [3:0]       dout_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       rdata_q;
`ifdef MEM_SEQ_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0]       wait_cnt_q;
    logic             error_q;
`endif

    logic       accept;
    logic       shift_en;
    logic [3:0] sh_msb;
    logic [3:0] sh_lsb;

    assign accept   = (state_q == ST_IDLE) && req_valid && is_access_op(req_op);
    // Shift on every bus nibble edge; in reads the DATA shifts capture mem_din
    assign shift_en = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);

    memory_sequencer_nibble_shifter #(
        .WIDTH (SHIFT_W)
    ) u_nibble_shifter (
        .clk_i       (clock),
        .rst_ni      (reset),
        .load_i      (accept),
        .load_word_i ({req_addr, req_wdata}),
        .shift_i     (shift_en),
        .nib_i       (mem_din),
        .msb_nib_o   (sh_msb),
        .lsb_nib_o   (sh_lsb)
    );

    // Access FSM; pin values are registered one edge ahead of each phase
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= REQ_NOP;
            nib_cnt_q <= '0;
            cs_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            dout_q    <= 4'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= 8'h00;
`ifdef MEM_SEQ_TIMEOUT_EN
            wait_cnt_q <= 4'h0;
            error_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_CMD;
                        op_q    <= mem_req_e'(req_op);
                        cs_n_q  <= 1'b0;
                        oe_q    <= 1'b1;
                        dout_q  <= (req_op == REQ_READ) ? CMD_READ : CMD_WRITE;
                        busy_q  <= 1'b1;
`ifdef MEM_SEQ_TIMEOUT_EN
                        error_q <= 1'b0;
`endif
                    end
                end
                ST_CMD: begin
                    state_q   <= ST_ADDR;
                    dout_q    <= sh_msb;
                    nib_cnt_q <= '0;
                end
                ST_ADDR: begin
                    if (nib_cnt_q == ADDR_LAST) begin
                        nib_cnt_q <= '0;
                        if (op_q == REQ_READ) begin
                            state_q <= ST_WAIT;
                            oe_q    <= 1'b0;
                            dout_q  <= 4'h0;
`ifdef MEM_SEQ_TIMEOUT_EN
                            wait_cnt_q <= 4'h0;
`endif
                        end else begin
                            state_q <= ST_DATA;
                            dout_q  <= sh_msb;
                        end
                    end else begin
                        nib_cnt_q <= nib_cnt_q + 1'b1;
                        dout_q    <= sh_msb;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        state_q <= ST_DATA;
                    end
`ifdef MEM_SEQ_TIMEOUT_EN
                    else if (wait_cnt_q == TIMEOUT_LAST) begin
                        state_q <= ST_DONE;
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        rdata_q <= 8'hFF;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'h1;
                    end
`endif
                end
                ST_DATA: begin
                    if (nib_cnt_q == '0) begin
                        nib_cnt_q <= CNT_W'(1);
                        if (op_q != REQ_READ) begin
                            dout_q <= sh_msb;
                        end
                    end else begin
                        nib_cnt_q <= '0;
                        state_q   <= ST_DONE;
                        cs_n_q    <= 1'b1;
                        oe_q      <= 1'b0;
                        dout_q    <= 4'h0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        if (op_q == REQ_READ) begin
                            rdata_q <= {sh_lsb, mem_din};
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_cs_n  = cs_n_q;
    assign mem_oe    = oe_q;
    assign mem_dout  = dout_q;
`ifdef MEM_SEQ_TIMEOUT_EN
    assign error     = error_q;
`else
    assign error     = 1'b0;
`endif

endmodule
